// File: rtl/epg_pkg.sv
// Shared types and constants for the epg_rx serial frame receiver.
package epg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DMAC,
    ST_SMAC,
    ST_LEN,
    ST_DATA,
    ST_FCS,
    ST_DRAIN
  } state_e;

  localparam int PRE_BITS = 64;
  localparam int MAC_BITS = 48;
  localparam int LEN_BITS = 16;
  localparam int FCS_BITS = 32;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // 62 alternating bits starting with 1, then the two SFD ones.
  function automatic logic preambleBit(input logic [5:0] idx);
    return (idx >= 6'd62) ? 1'b1 : ~idx[0];
  endfunction

endpackage

// File: rtl/epg_rx_shift.sv
// MSB-first field shifter shared by every field of epg_rx; shifted_o is the value
// including the bit currently on bit_i, so the top can capture a field on its last bit.
module epg_rx_shift #(
  parameter int W = 48
) (
  input  logic         clock,
  input  logic         clear_i,
  input  logic         shiftEn_i,
  input  logic         bit_i,
  output logic [W-1:0] shifted_o
);

  logic [W-1:0] data_q, data_d;

  assign shifted_o = {data_q[W-2:0], bit_i};

  always_comb begin
    data_d = data_q;
    if (clear_i) begin
      data_d = '0;
    end else if (shiftEn_i) begin
      data_d = shifted_o;
    end
  end

  always_ff @(posedge clock) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/epg_rx.sv
// Bit-serial Ethernet frame receiver: preamble/SFD check, header and FCS capture, payload byte strobes.
// Build option EPG_RX_ADDR_FILTER_EN adds localMAC destination filtering and a dropped pulse.
module epg_rx
  import epg_pkg::*;
#(
  parameter int maxLen   = 1500,
  parameter int lenWidth = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                packet,
  input  logic                packetValid,
`ifdef EPG_RX_ADDR_FILTER_EN
  input  logic [47:0]         localMAC,
  output logic                dropped,
`endif
  output logic [47:0]         dMAC,
  output logic [47:0]         sMAC,
  output logic [lenWidth-1:0] length,
  output logic [31:0]         FCS,
  output logic                headerValid,
  output logic [7:0]          dataOut,
  output logic                wr_en,
  output logic                frameDone,
  output logic                error
);

  state_e              state_q, state_d;
  logic [5:0]          bitCnt_q, bitCnt_d;
  logic [lenWidth-1:0] byteCnt_q, byteCnt_d, lenTgt_q, lenTgt_d, length_q, length_d;
  logic [47:0]         dTmp_q, dTmp_d, sTmp_q, sTmp_d, dMac_q, dMac_d, sMac_q, sMac_d;
  logic [31:0]         fcs_q, fcs_d;
  logic [7:0]          data_q, data_d;
  logic                accept_q, accept_d;
  logic                hv_q, hv_d, wr_q, wr_d, done_q, done_d, err_q, err_d;
`ifdef EPG_RX_ADDR_FILTER_EN
  logic                drop_q, drop_d;
`endif

  logic [47:0]         fieldNext;
  logic [lenWidth-1:0] lenField;
  logic                shiftEn, dstMatch;

  assign shiftEn  = packetValid && (state_q inside {ST_DMAC, ST_SMAC, ST_LEN, ST_DATA, ST_FCS});
  assign lenField = fieldNext[lenWidth-1:0];

  epg_rx_shift #(.W(MAC_BITS)) u_shift (
    .clock     (clock),
    .clear_i   (reset || (state_q == ST_IDLE)),
    .shiftEn_i (shiftEn),
    .bit_i     (packet),
    .shifted_o (fieldNext)
  );

`ifdef EPG_RX_ADDR_FILTER_EN
  assign dstMatch = (fieldNext == localMAC) || (fieldNext == BCAST_MAC);
`else
  assign dstMatch = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    byteCnt_d = byteCnt_q;
    lenTgt_d  = lenTgt_q;
    dTmp_d    = dTmp_q;
    sTmp_d    = sTmp_q;
    accept_d  = accept_q;
    dMac_d    = dMac_q;
    sMac_d    = sMac_q;
    length_d  = length_q;
    fcs_d     = fcs_q;
    data_d    = data_q;
    hv_d      = 1'b0;
    wr_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef EPG_RX_ADDR_FILTER_EN
    drop_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (packetValid) begin
          if (packet == preambleBit(6'd0)) begin
            state_d  = ST_PRE;
            bitCnt_d = 6'd1;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!packetValid) state_d = ST_IDLE;
      end
      default: begin
        // Losing packetValid mid-frame aborts straight to IDLE; a partial byte is discarded.
        if (!packetValid) begin
          err_d    = 1'b1;
          state_d  = ST_IDLE;
          bitCnt_d = '0;
        end else begin
          bitCnt_d = bitCnt_q + 6'd1;
          case (state_q)
            ST_PRE: begin
              if (packet != preambleBit(bitCnt_q)) begin
                err_d   = 1'b1;
                state_d = ST_DRAIN;
              end else if (bitCnt_q == 6'(PRE_BITS - 1)) begin
                state_d  = ST_DMAC;
                bitCnt_d = '0;
              end
            end
            ST_DMAC: begin
              if (bitCnt_q == 6'(MAC_BITS - 1)) begin
                dTmp_d   = fieldNext;
                accept_d = dstMatch;
                state_d  = ST_SMAC;
                bitCnt_d = '0;
              end
            end
            ST_SMAC: begin
              if (bitCnt_q == 6'(MAC_BITS - 1)) begin
                sTmp_d   = fieldNext;
                state_d  = ST_LEN;
                bitCnt_d = '0;
              end
            end
            ST_LEN: begin
              if (bitCnt_q == 6'(LEN_BITS - 1)) begin
                bitCnt_d  = '0;
                byteCnt_d = '0;
                lenTgt_d  = lenField;
                hv_d      = accept_q;
                if (accept_q) begin
                  dMac_d   = dTmp_q;
                  sMac_d   = sTmp_q;
                  length_d = lenField;
                end
                if (lenField > lenWidth'(maxLen)) begin
                  err_d   = 1'b1;
                  state_d = ST_DRAIN;
                end else if (lenField == '0) begin
                  state_d = ST_FCS;
                end else begin
                  state_d = ST_DATA;
                end
              end
            end
            ST_DATA: begin
              if (bitCnt_q == 6'd7) begin
                bitCnt_d  = '0;
                byteCnt_d = byteCnt_q + lenWidth'(1);
                wr_d      = accept_q;
                if (accept_q) data_d = fieldNext[7:0];
                if (byteCnt_q + lenWidth'(1) == lenTgt_q) state_d = ST_FCS;
              end
            end
            ST_FCS: begin
              if (bitCnt_q == 6'(FCS_BITS - 1)) begin
                state_d = ST_DRAIN;
                if (accept_q) begin
                  fcs_d  = fieldNext[31:0];
                  done_d = 1'b1;
                end
`ifdef EPG_RX_ADDR_FILTER_EN
                else begin
                  drop_d = 1'b1;
                end
`endif
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bitCnt_q  <= '0;
      byteCnt_q <= '0;
      lenTgt_q  <= '0;
      dTmp_q    <= '0;
      sTmp_q    <= '0;
      accept_q  <= 1'b0;
      dMac_q    <= '0;
      sMac_q    <= '0;
      length_q  <= '0;
      fcs_q     <= '0;
      data_q    <= '0;
      hv_q      <= 1'b0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef EPG_RX_ADDR_FILTER_EN
      drop_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      byteCnt_q <= byteCnt_d;
      lenTgt_q  <= lenTgt_d;
      dTmp_q    <= dTmp_d;
      sTmp_q    <= sTmp_d;
      accept_q  <= accept_d;
      dMac_q    <= dMac_d;
      sMac_q    <= sMac_d;
      length_q  <= length_d;
      fcs_q     <= fcs_d;
      data_q    <= data_d;
      hv_q      <= hv_d;
      wr_q      <= wr_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef EPG_RX_ADDR_FILTER_EN
      drop_q    <= drop_d;
`endif
    end
  end

  assign dMAC        = dMac_q;
  assign sMAC        = sMac_q;
  assign length      = length_q;
  assign FCS         = fcs_q;
  assign dataOut     = data_q;
  assign headerValid = hv_q;
  assign wr_en       = wr_q;
  assign frameDone   = done_q;
  assign error       = err_q;
`ifdef EPG_RX_ADDR_FILTER_EN
  assign dropped     = drop_q;
`endif

endmodule

// File: tb/tb_epg_rx.sv
// Bench for epg_rx: directed and $urandom frames, each predicted by an event-level model
// that places every pulse from the frame's field layout rather than from the FSM.
`timescale 1ns/1ps
module tb_epg_rx;

  localparam int MAX_LEN = 1500;
  localparam int HDR_END = 175;
  localparam int MAXP    = 13000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        packet = 1'b0;
  logic        packetValid = 1'b0;
  logic [47:0] dMAC, sMAC;
  logic [15:0] length;
  logic [31:0] FCS;
  logic        headerValid, wr_en, frameDone, error;
  logic [7:0]  dataOut;

  int checks = 0;
  int errors = 0;

  bit          bits[$];
  logic [47:0] fDmac, fSmac;
  logic [15:0] fLen;
  logic [31:0] fFcs;
  logic [7:0]  fData[$];

  logic [47:0] mDmac = '0, mSmac = '0;
  logic [15:0] mLen = '0;
  logic [31:0] mFcs = '0;
  logic [3:0]  expPulse[MAXP];
  logic [7:0]  expData[MAXP];

  epg_rx dut (
    .clock       (clock),
    .reset       (reset),
    .packet      (packet),
    .packetValid (packetValid),
    .dMAC        (dMAC),
    .sMAC        (sMAC),
    .length      (length),
    .FCS         (FCS),
    .headerValid (headerValid),
    .dataOut     (dataOut),
    .wr_en       (wr_en),
    .frameDone   (frameDone),
    .error       (error)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic setFields(input logic [47:0] d, input logic [47:0] s, input logic [15:0] l,
                           input logic [31:0] f);
    fDmac = d;
    fSmac = s;
    fLen  = l;
    fFcs  = f;
    fData.delete();
  endtask

  task automatic buildFrame(input int flipIdx);
    bits.delete();
    for (int i = 0; i < 64; i++) bits.push_back((i >= 62) || (i % 2 == 0));
    if (flipIdx >= 0) bits[flipIdx] = ~bits[flipIdx];
    for (int i = 47; i >= 0; i--) bits.push_back(fDmac[i]);
    for (int i = 47; i >= 0; i--) bits.push_back(fSmac[i]);
    for (int i = 15; i >= 0; i--) bits.push_back(fLen[i]);
    foreach (fData[k]) for (int i = 7; i >= 0; i--) bits.push_back(fData[k][i]);
    for (int i = 31; i >= 0; i--) bits.push_back(fFcs[i]);
  endtask

  // Bit i sampled -> its pulse is visible in period i+1; n = number of valid bits sent.
  task automatic modelFrame(input int n, input int flipIdx, input int resetAt);
    int idx;
    int fEnd;
    for (int p = 0; p < MAXP; p++) begin
      expPulse[p] = '0;
      expData[p]  = '0;
    end
    if (flipIdx >= 0 && flipIdx < n) begin
      expPulse[flipIdx + 1][0] = 1'b1;
    end else if (n <= HDR_END) begin
      expPulse[n + 1][0] = 1'b1;
    end else begin
      expPulse[HDR_END + 1][3] = 1'b1;
      mDmac = fDmac;
      mSmac = fSmac;
      mLen  = fLen;
      if (int'(fLen) > MAX_LEN) begin
        expPulse[HDR_END + 1][0] = 1'b1;
      end else begin
        for (int k = 0; k < int'(fLen); k++) begin
          idx = HDR_END + 8 * k + 8;
          if (idx < n) begin
            expPulse[idx + 1][2] = 1'b1;
            expData[idx + 1]     = fData[k];
          end
        end
        fEnd = HDR_END + 8 * int'(fLen) + 32;
        if (fEnd < n) begin
          expPulse[fEnd + 1][1] = 1'b1;
          mFcs = fFcs;
        end else begin
          expPulse[n + 1][0] = 1'b1;
        end
      end
    end
    if (resetAt >= 0) begin
      for (int p = resetAt + 1; p < MAXP; p++) expPulse[p] = '0;
      mDmac = '0;
      mSmac = '0;
      mLen  = '0;
      mFcs  = '0;
    end
  endtask

  task automatic applyStimulus(input string name, input int cut, input int flipIdx, input int resetAt);
    int nBits;
    int n;
    int total;
    logic [3:0] obs;
    buildFrame(flipIdx);
    nBits = bits.size();
    n = (cut >= 0 && cut < nBits) ? cut : nBits;
    if (resetAt >= 0) n = resetAt;
    modelFrame(n, flipIdx, resetAt);
    total = nBits + 4;
    for (int p = 0; p < total; p++) begin
      @(posedge clock);
      #1;
      obs = {headerValid, wr_en, frameDone, error};
      checkOutput($sformatf("%s pulses@%0d", name, p), 64'(obs), 64'(expPulse[p]));
      if (expPulse[p][2]) checkOutput($sformatf("%s dataOut@%0d", name, p), 64'(dataOut), 64'(expData[p]));
      if (resetAt >= 0 && p == resetAt + 1) begin
        checkOutput($sformatf("%s rst dMAC", name), 64'(dMAC), 64'd0);
        checkOutput($sformatf("%s rst sMAC", name), 64'(sMAC), 64'd0);
        checkOutput($sformatf("%s rst length", name), 64'(length), 64'd0);
        checkOutput($sformatf("%s rst FCS", name), 64'(FCS), 64'd0);
        checkOutput($sformatf("%s rst dataOut", name), 64'(dataOut), 64'd0);
      end
      reset       = (p == resetAt);
      packetValid = (p < n);
      packet      = (p < n) ? bits[p] : 1'b0;
    end
    checkOutput($sformatf("%s dMAC", name), 64'(dMAC), 64'(mDmac));
    checkOutput($sformatf("%s sMAC", name), 64'(sMAC), 64'(mSmac));
    checkOutput($sformatf("%s length", name), 64'(length), 64'(mLen));
    checkOutput($sformatf("%s FCS", name), 64'(FCS), 64'(mFcs));
  endtask

  task automatic setNominal();
    setFields(48'h0A1B2C3D4E5F, 48'h112233445566, 16'd4, 32'hDEADBEEF);
    fData.push_back(8'hA5);
    fData.push_back(8'h3C);
    fData.push_back(8'hFF);
    fData.push_back(8'h01);
  endtask

  initial begin
    int cut;
    reset       = 1'b1;
    packetValid = 1'b0;
    packet      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset pulses", 64'({headerValid, wr_en, frameDone, error}), 64'd0);
    checkOutput("reset dMAC", 64'(dMAC), 64'd0);
    checkOutput("reset sMAC", 64'(sMAC), 64'd0);
    checkOutput("reset length", 64'(length), 64'd0);
    checkOutput("reset FCS", 64'(FCS), 64'd0);
    checkOutput("reset dataOut", 64'(dataOut), 64'd0);
    reset = 1'b0;

    setNominal();
    applyStimulus("nominal", -1, -1, -1);

    setFields(48'hCAFE00000001, 48'h000000ABCDEF, 16'd0, 32'h12345678);
    applyStimulus("len0", -1, -1, -1);

    setNominal();
    applyStimulus("preflip", -1, 10, -1);
    setNominal();
    applyStimulus("afterflip", -1, -1, -1);

    setNominal();
    applyStimulus("cut2.5", HDR_END + 1 + 20, -1, -1);

    setFields(48'h665544332211, 48'h0F0E0D0C0B0A, 16'd1501, 32'h0BADF00D);
    for (int k = 0; k < 3; k++) fData.push_back(8'(8'h10 + k));
    applyStimulus("len1501", -1, -1, -1);

    setNominal();
    applyStimulus("resetmid", -1, -1, HDR_END + 13);
    setNominal();
    applyStimulus("afterreset", -1, -1, -1);

    setFields(48'h0123456789AB, 48'hBA9876543210, 16'd1500, 32'hFEEDFACE);
    for (int k = 0; k < 1500; k++) fData.push_back(8'($urandom));
    applyStimulus("len1500", -1, -1, -1);

    for (int r = 0; r < 8; r++) begin
      setFields({16'($urandom), $urandom}, {16'($urandom), $urandom},
                16'($urandom_range(0, 12)), $urandom);
      for (int k = 0; k < int'(fLen); k++) fData.push_back(8'($urandom));
      cut = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, HDR_END + 8 * int'(fLen) + 32)) : -1;
      applyStimulus($sformatf("rand%0d", r), cut, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/epg_rx.md
Name: epg_rx

Overview:
- Serial Ethernet frame receiver and deserializer; the receive-side counterpart of the team's bit-serial packet generator.
- Consumes the 1-bit `packet` stream qualified by `packetValid`, and checks preamble/SFD.
- Extracts destination MAC, source MAC, length and FCS; writes payload bytes to a downstream FIFO through a `wr_en` strobe.
- Sits between the serial link (or generator loopback) and the payload buffer.

Parameters:
- maxLen, 1500, largest accepted length field in bytes; larger values flag an error.
- lenWidth, 16, width of the length field and of the internal byte counter.

Ports:
- clock  input  1  single system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- packet  input  1  serial frame bit, MSB-first per field.
- packetValid  input  1  high for every cycle carrying a frame bit.
- dMAC  output  48  received destination MAC; held until next header.
- sMAC  output  48  received source MAC.
- length  output  16  received length field.
- FCS  output  32  received frame check sequence.
- headerValid  output  1  one-cycle pulse when dMAC/sMAC/length are updated.
- dataOut  output  8  assembled payload byte.
- wr_en  output  1  one-cycle pulse; dataOut valid this cycle.
- frameDone  output  1  one-cycle pulse after the last FCS bit.
- error  output  1  one-cycle pulse on any abort condition.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; shift register 0.
- A bit is sampled only on cycles with packetValid=1. The first such cycle in IDLE is preamble bit 0.
- Expected preamble/SFD is 64 bits: 62 alternating bits starting with 1 (1,0,1,0,...,1,0), then 1,1.
- States and transitions:
  - IDLE: on packetValid=1, go to PRE and compare bit 0.
  - PRE: compare each bit against the expected pattern. Mismatch -> error pulse, go to DRAIN. After bit 63 matches, go to DMAC.
  - DMAC: 48 bits MSB first, then SMAC.
  - SMAC: 48 bits, then LEN.
  - LEN: 16 bits. The cycle after the last bit: update dMAC/sMAC/length and pulse headerValid.
    - length > maxLen -> error pulse, go to DRAIN.
    - length == 0 -> go to FCS.
    - otherwise -> go to DATA.
  - DATA: shift 8 bits MSB first. The cycle after the 8th bit: dataOut = byte, wr_en = 1, byte counter +1. When the counter reaches length, go to FCS.
  - FCS: 32 bits. The cycle after the last bit: update FCS, pulse frameDone, go to DRAIN.
  - DRAIN: wait for packetValid=0, then go to IDLE. This guarantees at least one idle cycle between frames.
- Latency: each pulse (headerValid, wr_en, frameDone) occurs exactly 1 cycle after its final sampled bit.
- Header outputs update atomically only on a complete header. A partial header never alters them.
- packetValid falling in PRE/DMAC/SMAC/LEN/DATA/FCS -> error pulse, go directly to IDLE. Bytes already written stay written; no partial byte is written.
- packetValid staying high after the FCS is absorbed in DRAIN with no further output.
- Simultaneous events: the error pulse has priority; frameDone and error are never high in the same cycle.
- Reset mid-frame: immediate return to the reset state on the next edge; no pulses are generated.
- Counter widths: bit counter 6 bits; byte counter lenWidth bits; comparisons are done at lenWidth.

Optional Feature:
- Macro: EPG_RX_ADDR_FILTER_EN.
- Defined: adds input localMAC[47:0]. Frames whose dMAC is neither localMAC nor FF:FF:FF:FF:FF:FF are still parsed to the end, but are filtered:
  - wr_en is suppressed;
  - frameDone is suppressed;
  - headerValid is suppressed;
  - a one-cycle `dropped` output pulses in place of frameDone.
- Undefined: no localMAC/dropped ports; all frames are accepted.

Decomposition:
- Package epg_pkg holds:
  - state encoding localparams (IDLE, PRE, DMAC, SMAC, LEN, DATA, FCS, DRAIN);
  - field widths: PRE_BITS=64, MAC_BITS=48, LEN_BITS=16, FCS_BITS=32;
  - BCAST_MAC constant.
- One sub-module, epg_rx_shift: a 48-bit MSB-first shift register with load-enable and clear, reused for every field.

Test Plan:
- Nominal frame: dMAC=0x0A1B2C3D4E5F, sMAC=0x112233445566, length=4, data A5,3C,FF,01, FCS=0xDEADBEEF -> headerValid once; four wr_en pulses with bytes in order; FCS=0xDEADBEEF; frameDone 1 cycle after the last bit; error never asserts.
- length=0 with FCS=0x12345678 -> no wr_en; frameDone asserts; FCS captured correctly.
- Preamble bit 10 flipped -> error pulse 1 cycle later; no headerValid; the next well-formed frame is received correctly.
- packetValid dropped after 2.5 data bytes -> exactly 2 wr_en pulses, then an error pulse; state returns to IDLE.
- length=1501 -> headerValid and error pulses; no wr_en; DRAIN until packetValid falls.
- Reset asserted mid-DATA -> all outputs 0 next cycle; the following frame parses correctly. With EPG_RX_ADDR_FILTER_EN: dMAC mismatch -> dropped pulse and no wr_en; broadcast dMAC -> accepted.
